// File: rtl/hex_display_mux.sv
// Scanned hex display driver: DIGITS nibbles, PWM dimming, double-buffered load.
// Define HEX_DISPLAY_MUX_LZ_BLANK_EN for leading-zero suppression.
module hex_display_mux #(
    parameter int DIGITS       = 4,
    parameter int CNT_WIDTH    = 14,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*DIGITS-1:0]     i_data,
    input  logic [DIGITS-1:0]       i_dp,
    input  logic                    i_load,
    input  logic [BRIGHT_WIDTH-1:0] i_brightness,
    output logic                    o_busy,
    output logic                    o_frame,
    output logic [DIGITS-1:0]       o_anodes,
    output logic [7:0]              o_segments
);

    localparam int IW = $clog2(DIGITS);

    logic [CNT_WIDTH-1:0]    cnt;
    logic [IW-1:0]           idx;
    logic [4*DIGITS-1:0]     disp_data;
    logic [4*DIGITS-1:0]     pend_data;
    logic [DIGITS-1:0]       disp_dp;
    logic [DIGITS-1:0]       pend_dp;
    logic                    boundary;
    logic                    enable;
    logic                    blank;
    logic [BRIGHT_WIDTH-1:0] phase;
    logic [3:0]              nibble;
    logic [7:0]              code;
    logic [DIGITS-1:0]       onehot;

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0:    seg_code = 8'hFC;
            4'h1:    seg_code = 8'h60;
            4'h2:    seg_code = 8'hDA;
            4'h3:    seg_code = 8'hF2;
            4'h4:    seg_code = 8'h66;
            4'h5:    seg_code = 8'hB6;
            4'h6:    seg_code = 8'hBE;
            4'h7:    seg_code = 8'hE0;
            4'h8:    seg_code = 8'hFE;
            4'h9:    seg_code = 8'hF6;
            4'hA:    seg_code = 8'hEE;
            4'hB:    seg_code = 8'h3E;
            4'hC:    seg_code = 8'h9C;
            4'hD:    seg_code = 8'h7A;
            4'hE:    seg_code = 8'h9E;
            default: seg_code = 8'h8E;
        endcase
    endfunction

    assign boundary = (idx == IW'(DIGITS - 1)) && (&cnt);
    assign phase    = cnt[CNT_WIDTH-1 -: BRIGHT_WIDTH];
    assign enable   = phase < i_brightness;
    assign nibble   = disp_data[{idx, 2'b00} +: 4];
    assign code     = {seg_code(nibble)[7:1], disp_dp[idx]};
    assign onehot   = DIGITS'(1) << idx;

`ifdef HEX_DISPLAY_MUX_LZ_BLANK_EN
    logic [DIGITS-1:0] zero_up;

    // zero_up[k]: nibble k and every nibble above it are zero
    always_comb begin
        logic z;
        z = 1'b1;
        zero_up = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            z = z && (disp_data[4*k +: 4] == 4'h0);
            zero_up[k] = z;
        end
    end

    assign blank = (idx != '0) && zero_up[idx] && !disp_dp[idx];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (&cnt)
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Display buffer only changes on the frame boundary, so a frame never tears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data <= '0;
            disp_dp   <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            o_busy    <= 1'b0;
        end else begin
            if (i_load) begin
                pend_data <= i_data;
                pend_dp   <= i_dp;
            end
            if (boundary) begin
                o_busy <= 1'b0;
                if (i_load) begin
                    disp_data <= i_data;
                    disp_dp   <= i_dp;
                end else if (o_busy) begin
                    disp_data <= pend_data;
                    disp_dp   <= pend_dp;
                end
            end else if (i_load) begin
                o_busy <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_frame    <= 1'b0;
            o_anodes   <= '1;
            o_segments <= '0;
        end else begin
            o_frame    <= boundary;
            o_anodes   <= enable ? ~onehot : '1;
            o_segments <= (enable && !blank) ? code : 8'h00;
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux: vector table plus cycle scoreboard.
// Expected LZ results follow HEX_DISPLAY_MUX_LZ_BLANK_EN.
module tb_hex_display_mux;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        load;
    logic [1:0]  bright;
    logic        o_busy;
    logic        o_frame;
    logic [3:0]  o_anodes;
    logic [7:0]  o_segments;

    int n_cmp = 0;
    int n_err = 0;

    hex_display_mux #(
        .DIGITS(4),
        .CNT_WIDTH(4),
        .BRIGHT_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_data(data),
        .i_dp(dp),
        .i_load(load),
        .i_brightness(bright),
        .o_busy(o_busy),
        .o_frame(o_frame),
        .o_anodes(o_anodes),
        .o_segments(o_segments)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       busy;
        logic       frame;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  an;
        logic [7:0]  seg;
    } vec_t;

    exp_t q[$];

    logic [7:0] segtab [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2,
        8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E,
        8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    logic [3:0]  m_cnt;
    logic [1:0]  m_idx;
    logic [15:0] m_disp;
    logic [3:0]  m_ddp;
    logic [15:0] m_pend;
    logic [3:0]  m_pdp;
    logic        m_busy;

    task automatic chk(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s timeout", nm);
    endtask

    task automatic m_reset();
        m_cnt  = 0;
        m_idx  = 0;
        m_disp = 0;
        m_ddp  = 0;
        m_pend = 0;
        m_pdp  = 0;
        m_busy = 0;
        q.delete();
    endtask

    // One clock: predict, push, clock, pop and compare
    task automatic tick();
        exp_t e;
        exp_t g;
        logic en;
        logic bnd;
        logic blank;
        logic [3:0] nib;
        en    = m_cnt[3:2] < bright;
        nib   = m_disp[m_idx*4 +: 4];
        blank = 1'b0;
`ifdef HEX_DISPLAY_MUX_LZ_BLANK_EN
        blank = (m_idx != 0) && ((m_disp >> (4 * m_idx)) == 0)
                && !m_ddp[m_idx];
`endif
        e.an  = en ? ~(4'b0001 << m_idx) : 4'hF;
        e.seg = (en && !blank) ? (segtab[nib] | {7'b0, m_ddp[m_idx]})
                               : 8'h00;
        bnd     = (m_idx == 2'd3) && (m_cnt == 4'hF);
        e.frame = bnd;
        if (bnd) begin
            if (load) begin
                m_disp = data;
                m_ddp  = dp;
            end else if (m_busy) begin
                m_disp = m_pend;
                m_ddp  = m_pdp;
            end
            m_busy = 1'b0;
        end
        if (load) begin
            m_pend = data;
            m_pdp  = dp;
            if (!bnd) m_busy = 1'b1;
        end
        e.busy = m_busy;
        if (m_cnt == 4'hF) m_idx = m_idx + 1'b1;
        m_cnt = m_cnt + 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk("scoreboard",
            {2'b0, o_anodes, o_segments, o_busy, o_frame},
            {2'b0, g});
        @(negedge clk);
    endtask

    task automatic wait_frame(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (o_frame) seen = 1;
        end
        if (!seen) timeout(nm);
    endtask

    task automatic check_digit(input logic [3:0] an,
                               input logic [7:0] seg,
                               input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            if (o_anodes == an) seen = 1;
        end
        if (!seen) timeout(nm);
        else chk(nm, {8'h0, o_segments}, {8'h0, seg});
    endtask

    task automatic load_word(input logic [15:0] d,
                             input logic [3:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic count_lit(input logic [1:0] b,
                             input int exp,
                             input string nm);
        int lit;
        lit = 0;
        bright = b;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (o_anodes != 4'hF) lit++;
        end
        chk(nm, 16'(lit), 16'(exp));
    endtask

`ifdef HEX_DISPLAY_MUX_LZ_BLANK_EN
    localparam logic [7:0] LZ_SEG = 8'h00;
`else
    localparam logic [7:0] LZ_SEG = 8'hFC;
`endif

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{16'h12AF, 4'b0000, 4'b1110, 8'h8E};
        vecs[1]  = '{16'h12AF, 4'b0000, 4'b1101, 8'hEE};
        vecs[2]  = '{16'h12AF, 4'b0000, 4'b1011, 8'hDA};
        vecs[3]  = '{16'h12AF, 4'b0000, 4'b0111, 8'h60};
        vecs[4]  = '{16'h12AF, 4'b0100, 4'b1011, 8'hDB};
        vecs[5]  = '{16'h12AF, 4'b0100, 4'b1110, 8'h8E};
        vecs[6]  = '{16'h3456, 4'b0001, 4'b1110, 8'hBF};
        vecs[7]  = '{16'h0070, 4'b0000, 4'b0111, LZ_SEG};
        vecs[8]  = '{16'h0070, 4'b0000, 4'b1011, LZ_SEG};
        vecs[9]  = '{16'h0070, 4'b0000, 4'b1101, 8'hE0};
        vecs[10] = '{16'h0070, 4'b0000, 4'b1110, 8'hFC};
        vecs[11] = '{16'h89CD, 4'b0000, 4'b0111, 8'hFE};
        vecs[12] = '{16'h89CD, 4'b0000, 4'b1101, 8'h9C};
        vecs[13] = '{16'h0070, 4'b1000, 4'b0111, 8'hFD};

        rst    = 1'b1;
        load   = 1'b0;
        data   = 16'h0;
        dp     = 4'h0;
        bright = 2'd3;
        m_reset();
        #12;
        chk("rst_anodes", {12'h0, o_anodes}, 16'h000F);
        chk("rst_segments", {8'h0, o_segments}, 16'h0000);
        chk("rst_busy_frame", {14'h0, o_busy, o_frame}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        check_digit(4'b1110, 8'hFC, "post_reset_d0");

        for (int i = 0; i < 14; i++) begin
            load_word(vecs[i].data, vecs[i].dp);
            wait_frame($sformatf("vec%0d_frame", i));
            check_digit(vecs[i].an, vecs[i].seg,
                        $sformatf("vec%0d_seg", i));
        end

        load_word(16'h12AF, 4'b0000);
        wait_frame("bright_frame");
        count_lit(2'd0, 0, "bright0_lit");
        count_lit(2'd1, 16, "bright1_lit");
        count_lit(2'd3, 48, "bright3_lit");

        wait_frame("tear_frame");
        check_digit(4'b1101, 8'hEE, "tear_d1_old");
        load_word(16'h0000, 4'b0000);
        chk("tear_busy_set", {15'h0, o_busy}, 16'h1);
        check_digit(4'b1011, 8'hDA, "tear_d2_old");
        check_digit(4'b0111, 8'h60, "tear_d3_old");
        chk("tear_busy_hold", {15'h0, o_busy}, 16'h1);
        wait_frame("tear_frame2");
        chk("tear_busy_clr", {15'h0, o_busy}, 16'h0);
        check_digit(4'b1110, 8'hFC, "tear_d0_new");
        check_digit(4'b0111, LZ_SEG, "tear_d3_new");

        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 100 && !hit; i++) begin
                if (m_idx == 2'd3 && m_cnt == 4'hF) hit = 1;
                else tick();
            end
            if (!hit) timeout("coin_wait");
        end
        load_word(16'h4321, 4'b0000);
        chk("coin_busy", {15'h0, o_busy}, 16'h0);
        chk("coin_frame", {15'h0, o_frame}, 16'h1);
        check_digit(4'b1110, 8'h60, "coin_d0");
        check_digit(4'b0111, 8'h66, "coin_d3");

        wait_frame("midrst_frame");
        tick();
        tick();
        load_word(16'h8888, 4'b1111);
        tick();
        chk("midrst_busy_pre", {15'h0, o_busy}, 16'h1);
        rst = 1'b1;
        #1;
        chk("midrst_anodes", {12'h0, o_anodes}, 16'h000F);
        chk("midrst_segments", {8'h0, o_segments}, 16'h0000);
        chk("midrst_busy", {15'h0, o_busy}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        check_digit(4'b1110, 8'hFC, "midrst_d0");
        wait_frame("midrst_frame2");
        check_digit(4'b1101, LZ_SEG, "midrst_lost");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
